// File: rtl/starflux_pkg.sv
// Shared types, widths and arithmetic helpers for the Starflux game-state path.
package starflux_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAYING  = 2'd1,
    GAMEOVER = 2'd2
  } state_t;

  localparam int SCORE_W  = 8;
  localparam int HEALTH_W = 4;

  // Add two score values and clamp to the all-ones maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and registered game-state outputs of the score keeper.
interface score_keeper_if;
  import starflux_pkg::*;

  logic                start;
  logic                kill;
  logic                hit;
  logic [SCORE_W-1:0]  score;
  logic [SCORE_W-1:0]  high_score;
  logic [HEALTH_W-1:0] health;
  logic                score_valid;
  logic                playing;
  logic                game_over;

  // The game logic side that raises events and watches the display values.
  modport master (
    output start, kill, hit,
    input  score, high_score, health, score_valid, playing, game_over
  );

  // The score keeper itself.
  modport slave (
    input  start, kill, hit,
    output score, high_score, health, score_valid, playing, game_over
  );

endinterface

// File: rtl/score_keeper_rise_detect.sv
// Turns a level input into a single-cycle pulse on its 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level; clearing it lets a level held through reset count once.
  always_ff @(posedge clk) begin
    if (!resetn) prev <= 1'b0;
    else         prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Game-state producer: play/idle/game-over FSM, invulnerability window and score arithmetic.
module score_keeper
  import starflux_pkg::*;
#(
  parameter int HEALTH_INIT   = 15,
  parameter int KILL_POINTS   = 1,
  parameter int INVULN_CYCLES = 4,
  parameter int GAMEOVER_HOLD = 8
) (
  input logic           clk,
  input logic           resetn,
  score_keeper_if.slave bus
);

  localparam int INVULN_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
  localparam int HOLD_W   = (GAMEOVER_HOLD > 1) ? $clog2(GAMEOVER_HOLD) : 1;

  state_t              state, state_n;
  logic [SCORE_W-1:0]  score, score_n;
  logic [SCORE_W-1:0]  high_score, high_score_n;
  logic [HEALTH_W-1:0] health, health_n;
  logic [INVULN_W-1:0] invuln, invuln_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic                score_valid, score_valid_n;
  logic                start_strobe;
  logic                start_ev, kill_ev, hit_ev;
  logic                hit_ok, fatal;

  rise_detect u_start (.clk(clk), .resetn(resetn), .d(bus.start), .pulse(start_ev));
  rise_detect u_kill  (.clk(clk), .resetn(resetn), .d(bus.kill),  .pulse(kill_ev));
  rise_detect u_hit   (.clk(clk), .resetn(resetn), .d(bus.hit),   .pulse(hit_ev));

  // A hit only counts while playing and outside the post-hit invulnerability window.
  assign hit_ok = (state == PLAYING) && hit_ev && (invuln == '0);
  assign fatal  = hit_ok && (health == HEALTH_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decision: start begins play, the last health point ends it, hold timer returns to idle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start_ev)     state_n = PLAYING;
      PLAYING:  if (fatal)        state_n = GAMEOVER;
      GAMEOVER: if (hold == '0)   state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    bus.playing   = (state == PLAYING);
    bus.game_over = (state == GAMEOVER);
  end

  // Next score/health/timer values; a kill landing with the fatal hit is folded into the final score.
  always_comb begin
    score_n      = score;
    high_score_n = high_score;
    health_n     = health;
    invuln_n     = invuln;
    hold_n       = hold;
    start_strobe = 1'b0;
    case (state)
      IDLE: begin
        if (start_ev) begin
          score_n      = '0;
          health_n     = HEALTH_W'(HEALTH_INIT);
          invuln_n     = '0;
          start_strobe = 1'b1;
        end
      end
      PLAYING: begin
        if (invuln != '0) invuln_n = invuln - INVULN_W'(1);
        if (kill_ev)      score_n  = sat_add(score, SCORE_W'(KILL_POINTS));
        if (hit_ok) begin
          health_n = health - HEALTH_W'(1);
          invuln_n = INVULN_W'(INVULN_CYCLES);
        end
        if (fatal) begin
          high_score_n = (score_n > high_score) ? score_n : high_score;
          hold_n       = HOLD_W'(GAMEOVER_HOLD - 1);
        end
      end
      GAMEOVER: begin
        if (hold != '0) hold_n = hold - HOLD_W'(1);
      end
      default: ;
    endcase
    score_valid_n = start_strobe || (score_n != score) || (health_n != health);
  end

  // Datapath registers, including the one-cycle strobe announcing changed display values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      score       <= '0;
      high_score  <= '0;
      health      <= HEALTH_W'(HEALTH_INIT);
      invuln      <= '0;
      hold        <= '0;
      score_valid <= 1'b0;
    end else begin
      score       <= score_n;
      high_score  <= high_score_n;
      health      <= health_n;
      invuln      <= invuln_n;
      hold        <= hold_n;
      score_valid <= score_valid_n;
    end
  end

  assign bus.score       = score;
  assign bus.high_score  = high_score;
  assign bus.health      = health;
  assign bus.score_valid = score_valid;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: default instance plus a KILL_POINTS=100 instance for saturation.
module tb_score_keeper;

  logic clk;
  logic resetn;

  score_keeper_if bus_a ();
  score_keeper_if bus_b ();

  score_keeper dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a)
  );

  score_keeper #(.KILL_POINTS(100)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected output snapshot, queued when the stimulus for that cycle is driven.
  typedef struct packed {
    logic       sel;
    logic [7:0] score;
    logic [3:0] health;
    logic [7:0] hs;
    logic       valid;
    logic       play;
    logic       go;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int checks = 0;
  int errors = 0;

  // Expected state, advanced by hand in the stimulus sequence below.
  logic       sel_b;
  logic [7:0] m_score;
  logic [3:0] m_health;
  logic [7:0] m_hs;
  logic       m_play;
  logic       m_go;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of events on the selected instance and queue what should appear after the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic k, input logic h, input logic v);
    exp_t e;
    if (sel_b) begin
      bus_b.start = s; bus_b.kill = k; bus_b.hit = h;
      bus_a.start = 1'b0; bus_a.kill = 1'b0; bus_a.hit = 1'b0;
    end else begin
      bus_a.start = s; bus_a.kill = k; bus_a.hit = h;
      bus_b.start = 1'b0; bus_b.kill = 1'b0; bus_b.hit = 1'b0;
    end
    e.sel = sel_b; e.score = m_score; e.health = m_health; e.hs = m_hs;
    e.valid = v; e.play = m_play; e.go = m_go;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer: one cycle after each queued stimulus, compare the registered outputs.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (e.sel) begin
          checkOutput({t, ".score"},  32'(bus_b.score),       32'(e.score));
          checkOutput({t, ".health"}, 32'(bus_b.health),      32'(e.health));
          checkOutput({t, ".high"},   32'(bus_b.high_score),  32'(e.hs));
          checkOutput({t, ".valid"},  32'(bus_b.score_valid), 32'(e.valid));
          checkOutput({t, ".play"},   32'(bus_b.playing),     32'(e.play));
          checkOutput({t, ".go"},     32'(bus_b.game_over),   32'(e.go));
        end else begin
          checkOutput({t, ".score"},  32'(bus_a.score),       32'(e.score));
          checkOutput({t, ".health"}, 32'(bus_a.health),      32'(e.health));
          checkOutput({t, ".high"},   32'(bus_a.high_score),  32'(e.hs));
          checkOutput({t, ".valid"},  32'(bus_a.score_valid), 32'(e.valid));
          checkOutput({t, ".play"},   32'(bus_a.playing),     32'(e.play));
          checkOutput({t, ".go"},     32'(bus_a.game_over),   32'(e.go));
        end
      end
    end
  end

  // Watchdog so a broken sequence can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence, following the game from reset through two full games, a mid-game reset and saturation.
  initial begin
    resetn = 1'b0;
    sel_b  = 1'b0;
    bus_a.start = 1'b0; bus_a.kill = 1'b0; bus_a.hit = 1'b0;
    bus_b.start = 1'b0; bus_b.kill = 1'b0; bus_b.hit = 1'b0;
    m_score = 8'd0; m_health = 4'd15; m_hs = 8'd0; m_play = 1'b0; m_go = 1'b0;
    #2;

    applyStimulus("reset0", 0, 0, 0, 0);
    applyStimulus("reset1", 0, 0, 0, 0);
    resetn = 1'b1;

    // Events before start are ignored.
    applyStimulus("idle_kill", 0, 1, 0, 0);
    applyStimulus("idle_low",  0, 0, 0, 0);
    applyStimulus("idle_hit",  0, 0, 1, 0);
    applyStimulus("idle_low",  0, 0, 0, 0);

    m_play = 1'b1;
    applyStimulus("start",     1, 0, 0, 1);
    applyStimulus("start_low", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      m_score = m_score + 8'd1;
      applyStimulus("kill",     0, 1, 0, 1);
      applyStimulus("kill_low", 0, 0, 0, 0);
    end

    // A held kill is a single event.
    m_score = m_score + 8'd1;
    applyStimulus("kill_hold_first", 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus("kill_hold", 0, 1, 0, 0);
    applyStimulus("kill_rel", 0, 0, 0, 0);

    // Second hit inside the window is dropped; one five cycles later lands.
    m_health = 4'd14;
    applyStimulus("hit1",       0, 0, 1, 1);
    applyStimulus("hit_low",    0, 0, 0, 0);
    applyStimulus("hit_invuln", 0, 0, 1, 0);
    applyStimulus("hit_low",    0, 0, 0, 0);
    applyStimulus("hit_low",    0, 0, 0, 0);
    m_health = 4'd13;
    applyStimulus("hit_late",   0, 0, 1, 1);

    for (int i = 0; i < 5; i++) begin
      m_score = m_score + 8'd1;
      applyStimulus("kill_to9", 0, 1, 0, 1);
      applyStimulus("kill_low", 0, 0, 0, 0);
    end

    while (m_health > 4'd1) begin
      m_health = m_health - 4'd1;
      applyStimulus("hit_loop", 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) applyStimulus("hit_wait", 0, 0, 0, 0);
    end

    // Kill and fatal hit on the same edge: the kill counts toward the high score.
    m_score = 8'd10; m_health = 4'd0; m_hs = 8'd10; m_play = 1'b0; m_go = 1'b1;
    applyStimulus("fatal",     0, 1, 1, 1);
    applyStimulus("go_low",    0, 0, 0, 0);
    applyStimulus("go_ignore", 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus("go_hold", 0, 0, 0, 0);
    m_go = 1'b0;
    applyStimulus("go_exit", 0, 0, 0, 0);

    // Second game ends lower; high score must stay.
    m_play = 1'b1; m_score = 8'd0; m_health = 4'd15;
    applyStimulus("start2",     1, 0, 0, 1);
    applyStimulus("start2_low", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      m_score = m_score + 8'd1;
      applyStimulus("kill2",     0, 1, 0, 1);
      applyStimulus("kill2_low", 0, 0, 0, 0);
    end
    while (m_health > 4'd1) begin
      m_health = m_health - 4'd1;
      applyStimulus("hit2_loop", 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) applyStimulus("hit2_wait", 0, 0, 0, 0);
    end
    m_health = 4'd0; m_play = 1'b0; m_go = 1'b1;
    applyStimulus("fatal2", 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) applyStimulus("go2_hold", 0, 0, 0, 0);
    m_go = 1'b0;
    applyStimulus("go2_exit", 0, 0, 0, 0);

    // Third game interrupted by reset while start is held high.
    m_play = 1'b1; m_score = 8'd0; m_health = 4'd15;
    applyStimulus("start3",     1, 0, 0, 1);
    applyStimulus("start3_low", 0, 0, 0, 0);
    m_score = 8'd1;
    applyStimulus("kill3",      0, 1, 0, 1);
    applyStimulus("start_play", 1, 0, 0, 0);
    resetn = 1'b0;
    m_score = 8'd0; m_health = 4'd15; m_hs = 8'd0; m_play = 1'b0; m_go = 1'b0;
    applyStimulus("mid_reset", 1, 0, 0, 0);
    resetn = 1'b1;
    m_play = 1'b1;
    applyStimulus("release_start", 1, 0, 0, 1);
    applyStimulus("release_low",   0, 0, 0, 0);

    // Saturation on the KILL_POINTS=100 instance.
    sel_b = 1'b1;
    m_score = 8'd0; m_health = 4'd15; m_hs = 8'd0; m_play = 1'b1; m_go = 1'b0;
    applyStimulus("b_start", 1, 0, 0, 1);
    applyStimulus("b_low",   0, 0, 0, 0);
    m_score = 8'd100;
    applyStimulus("b_kill100", 0, 1, 0, 1);
    applyStimulus("b_low",     0, 0, 0, 0);
    m_score = 8'd200;
    applyStimulus("b_kill200", 0, 1, 0, 1);
    applyStimulus("b_low",     0, 0, 0, 0);
    m_score = 8'd255;
    applyStimulus("b_kill_sat", 0, 1, 0, 1);
    applyStimulus("b_low",      0, 0, 0, 0);
    applyStimulus("b_kill_at_max", 0, 1, 0, 0);
    applyStimulus("b_low",         0, 0, 0, 0);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
